// File: rtl/sx_tx_drv.sv
// Serial stimulus transmitter: accepts a parallel word on valid/ready and
// shifts it out MSB first on x_o, holding each bit for HOLD clocks.
module sx_tx_drv #(
  parameter int   WIDTH  = 8,
  parameter int   HOLD   = 1,
  parameter logic IDLE_X = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             x_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH);
  // HOLD=1 still needs a one-bit hold counter so the compare stays well formed
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    bcnt_q, bcnt_d;
  logic [HW-1:0]    hcnt_q, hcnt_d;
  logic             last_hold_s;
  logic             last_bit_s;

  assign last_hold_s = (hcnt_q == HW'(HOLD - 1));
  assign last_bit_s  = (bcnt_q == CW'(WIDTH - 1));

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      sreg_q  <= {WIDTH{1'b0}};
      bcnt_q  <= {CW{1'b0}};
      hcnt_q  <= {HW{1'b0}};
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bcnt_q  <= bcnt_d;
      hcnt_q  <= hcnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (valid_i) state_d = ST_SHIFT;
        else         state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        if (last_hold_s && last_bit_s) state_d = ST_DONE;
        else                           state_d = ST_SHIFT;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Shift register and counters; data_i is only looked at on accept
  always_comb begin
    sreg_d = sreg_q;
    bcnt_d = bcnt_q;
    hcnt_d = hcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          sreg_d = data_i;
          bcnt_d = {CW{1'b0}};
          hcnt_d = {HW{1'b0}};
        end else begin
          sreg_d = sreg_q;
        end
      end
      ST_SHIFT: begin
        if (last_hold_s) begin
          hcnt_d = {HW{1'b0}};
          if (!last_bit_s) begin
            sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            bcnt_d = bcnt_q + CW'(1);
          end else begin
            bcnt_d = bcnt_q;
          end
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      ST_DONE: sreg_d = sreg_q;
      default: sreg_d = sreg_q;
    endcase
  end

  // Outputs decoded from state and the registered shift MSB only
  always_comb begin
    ready_o = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    x_o     = IDLE_X;
    case (state_q)
      ST_IDLE:  ready_o = 1'b1;
      ST_SHIFT: begin
        busy_o = 1'b1;
        x_o    = sreg_q[WIDTH-1];
      end
      ST_DONE:  done_o = 1'b1;
      default:  ready_o = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_sx_tx_drv.sv
// Directed scoreboard bench for sx_tx_drv: two instances (HOLD=1 and HOLD=3)
// checked cycle by cycle against expectations queued when stimulus is driven.
module tb_sx_tx_drv;

  logic       clk;
  logic       rst;
  logic [3:0] d1, d3;
  logic       v1, v3;
  logic       r1, x1, b1, dn1;
  logic       r3, x3, b3, dn3;

  logic [3:0] exp_q[$];
  int         n_checks;
  int         n_fail;
  int         done_cnt;
  logic       sel;
  string      seg;

  sx_tx_drv #(.WIDTH(4), .HOLD(1), .IDLE_X(1'b0)) u_h1 (
    .clk_i(clk), .rst_i(rst), .data_i(d1), .valid_i(v1),
    .ready_o(r1), .x_o(x1), .busy_o(b1), .done_o(dn1)
  );

  sx_tx_drv #(.WIDTH(4), .HOLD(3), .IDLE_X(1'b1)) u_h3 (
    .clk_i(clk), .rst_i(rst), .data_i(d3), .valid_i(v3),
    .ready_o(r3), .x_o(x3), .busy_o(b3), .done_o(dn3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed expectation: {x, ready, busy, done}
  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed {x,rdy,busy,done}=%b required %b", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, expv);
    end
  endtask

  task automatic push_frame(input logic [3:0] d, input int hold, input logic ix);
    for (int k = 3; k >= 0; k--)
      for (int h = 0; h < hold; h++)
        exp_q.push_back({d[k], 1'b0, 1'b1, 1'b0});
    exp_q.push_back({ix, 1'b0, 1'b0, 1'b1});
  endtask

  task automatic push_idle(input int n, input logic ix);
    for (int i = 0; i < n; i++) exp_q.push_back({ix, 1'b1, 1'b0, 1'b0});
  endtask

  task automatic tick();
    logic [3:0] obs;
    @(negedge clk);
    obs = sel ? {x3, r3, b3, dn3} : {x1, r1, b1, dn1};
    if (obs[0] === 1'b1) done_cnt++;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s_underflow: observed %b required no output (queue empty)", seg, obs);
    end else begin
      check4(seg, obs, exp_q.pop_front());
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; done_cnt = 0; sel = 1'b0;
    rst = 1'b0; v1 = 1'b0; v3 = 1'b0; d1 = 4'd0; d3 = 4'd0;

    // Reset asserted between edges must take effect without a clock
    seg = "reset";
    #2 rst = 1'b1;
    #1;
    check4("reset_h1", {x1, r1, b1, dn1}, 4'b0100);
    check4("reset_h3", {x3, r3, b3, dn3}, 4'b1100);
    @(negedge clk);
    rst = 1'b0;
    seg = "idle";
    push_idle(2, 1'b0);
    tick(); tick();

    // Basic frame 1011 with an ignored 0000 request at t0+2
    seg = "basic"; done_cnt = 0;
    v1 = 1'b1; d1 = 4'b1011;
    push_frame(4'b1011, 1, 1'b0);
    tick();
    v1 = 1'b1; d1 = 4'b0000;
    tick();
    v1 = 1'b0;
    tick(); tick(); tick();
    push_idle(3, 1'b0);
    tick(); tick(); tick();
    check_int("basic_done_count", done_cnt, 1);

    // Hold stretch on the HOLD=3 instance
    sel = 1'b1; seg = "hold3"; done_cnt = 0;
    push_idle(1, 1'b1);
    tick();
    v3 = 1'b1; d3 = 4'b0110;
    push_frame(4'b0110, 3, 1'b1);
    tick();
    v3 = 1'b0;
    repeat (12) tick();
    push_idle(2, 1'b1);
    tick(); tick();
    check_int("hold3_done_count", done_cnt, 1);

    // Back-to-back frames with valid held high
    sel = 1'b0; seg = "b2b"; done_cnt = 0;
    v1 = 1'b1; d1 = 4'b1000;
    push_frame(4'b1000, 1, 1'b0);
    tick();
    d1 = 4'b0001;
    repeat (4) tick();
    push_idle(1, 1'b0);
    tick();
    push_frame(4'b0001, 1, 1'b0);
    tick();
    v1 = 1'b0;
    repeat (4) tick();
    push_idle(2, 1'b0);
    tick(); tick();
    check_int("b2b_done_count", done_cnt, 2);

    // Mid-frame reset aborts without done, then a fresh frame
    seg = "abort"; done_cnt = 0;
    v1 = 1'b1; d1 = 4'b1011;
    push_frame(4'b1011, 1, 1'b0);
    tick();
    v1 = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check4("abort_immediate", {x1, r1, b1, dn1}, 4'b0100);
    exp_q.delete();
    @(negedge clk);
    check4("abort_held", {x1, r1, b1, dn1}, 4'b0100);
    rst = 1'b0;
    push_idle(1, 1'b0);
    tick();
    seg = "after_abort";
    v1 = 1'b1; d1 = 4'b0101;
    push_frame(4'b0101, 1, 1'b0);
    tick();
    v1 = 1'b0;
    repeat (4) tick();
    push_idle(1, 1'b0);
    tick();
    check_int("after_abort_done_count", done_cnt, 1);
    check_int("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
